gpu_blitter: RTL and testbench
==============================

Name: gpu_blitter

Overview:
- Next-generation GPU draw engine: copies a rectangular excerpt of a 16-bit image from memory into the framebuffer, or fills a rectangle with a constant colour.
- Sits between the command controller, the shared memory port and the framebuffer write port.
- Adds pipelined memory reads with up to MAX_OUTSTANDING requests in flight, a memory ready handshake, horizontal/vertical flip, signed (off-screen) placement, rectangle fill and an opaque blit mode.

Parameters:
- FB_WIDTH, 400, framebuffer width in pixels.
- FB_HEIGHT, 240, framebuffer height in pixels.
- MAX_OUTSTANDING, 4, maximum read requests in flight; power of two, at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  out  32  byte address of the requested pixel.
- mem_read  out  1  read request; a transfer occurs when mem_read && mem_ready.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_data  in  16  returned pixel; responses return in request order.
- mem_valid  in  1  mem_data is valid this cycle.
- ctrl_address  in  32  image base address in bytes.
- ctrl_address_x, ctrl_address_y  in  16 each  source excerpt offset in pixels.
- ctrl_image_width  in  16  source image width in pixels.
- ctrl_width  in  CW=$clog2(FB_WIDTH)+3  excerpt width, unsigned.
- ctrl_height  in  CH=$clog2(FB_HEIGHT)+3  excerpt height, unsigned.
- ctrl_x  in  CW  destination left edge, signed two's complement.
- ctrl_y  in  CH  destination top edge, signed two's complement.
- ctrl_mode  in  2  00 blit (transparency via bit0), 01 fill, 10 opaque blit, 11 reserved (treated as 00).
- ctrl_flip_x, ctrl_flip_y  in  1 each  mirror the source horizontally / vertically.
- ctrl_color  in  16  fill colour.
- ctrl_start  in  1  a rising edge starts a command.
- ctrl_busy  out  1  high while a command is executing.
- fb_x  out  $clog2(FB_WIDTH)+1  destination x.
- fb_y  out  $clog2(FB_HEIGHT)+1  destination y.
- fb_color  out  16  pixel colour.
- fb_write  out  1  write strobe.

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; counters and tag FIFO cleared; start-edge register cleared.
  - mem_read, fb_write and ctrl_busy go 0 immediately; mem_addr, fb_x, fb_y and fb_color go 0.
  - Reset mid-command abandons the command; responses still in flight afterwards are ignored.
- Start: rising edge on ctrl_start sampled in IDLE at edge N.
  - All ctrl_* inputs are latched at edge N.
  - State moves to ISSUE (blit) or FILL at edge N.
  - ctrl_busy is high from the cycle after N. An edge seen while busy is ignored and not queued.
- Zero size: width==0 or height==0 returns to IDLE after one busy cycle. No memory reads and no writes occur.
- Traversal: row-major; col 0..W-1 within row 0..H-1.
  - Source column sc = flip_x ? W-1-col : col.
  - Source row sr = flip_y ? H-1-row : row.
  - mem_addr = base + 2*((addr_y+sr)*image_width + addr_x+sc), computed modulo 2^32.
- ISSUE state:
  - mem_read is high while requests remain and outstanding < MAX_OUTSTANDING.
  - On each accepted transfer: push destination (x+col, y+row) into the tag FIFO, then advance col/row.
  - mem_addr is held stable while mem_read is high and mem_ready is low.
  - After the last request is accepted, move to DRAIN.
- Responses (ISSUE or DRAIN):
  - On mem_valid, pop one tag and drive fb_x/fb_y from it and fb_color=mem_data.
  - fb_write is combinational in that same cycle.
  - A request accepted and a response received in the same cycle leave outstanding unchanged.
  - mem_valid with outstanding==0 is ignored.
  - DRAIN returns to IDLE on the cycle outstanding reaches 0; ctrl_busy is low the following cycle.
- FILL state:
  - One pixel per cycle with fb_color=ctrl_color, no memory traffic.
  - Returns to IDLE after W*H cycles.
- Write enable: fb_write = active pixel && 0<=dx<FB_WIDTH && 0<=dy<FB_HEIGHT (signed compare) && (mode!=00 || colour[0]).
  - fb_x/fb_y carry the low bits of dx/dy.
- Throughput: one pixel per cycle once the pipeline is full and mem_ready is high.

Test Plan:
- Blit 4x2 at (10,5), base 0x1000, addr_x=2, addr_y=1, image_width=16, zero-latency memory, all pixels with bit0=1 -> mem_addr sequence 0x1024,0x1026,0x1028,0x102A,0x1044.. and 8 fb_writes at (10..13, 5..6).
- Same blit with ctrl_flip_x=1 and ctrl_flip_y=1 -> first mem_addr 0x104A, last 0x1024; destination order unchanged.
- Memory latency 6 cycles with mem_ready toggling -> outstanding never exceeds 4; all 8 writes arrive in order; mem_addr is stable while stalled.
- Fill 3x3 at x=-1, y=238, colour 0x1234 -> exactly 9 active cycles; writes only at x 0..1, y 238..239 (4 writes); no mem_read.
- Blit with pixel 0x0002 in mode 00 -> no write for that pixel; in mode 10 -> written with colour 0x0002.
- Assert reset during DRAIN with 3 requests outstanding -> ctrl_busy/fb_write drop immediately; late mem_valid produces no write; the next start runs normally.

Source files
------------

// File: rtl/gpu_blitter.sv
// gpu_blitter: rectangle copy / fill engine feeding a framebuffer write port.
//
// Blit modes read source pixels through a pipelined memory port. Up to
// MAX_OUTSTANDING reads may be in flight. Each accepted read pushes its
// destination coordinate into a small tag FIFO. Each in-order response pops
// one tag, and the pixel is written in that same cycle.
// Fill mode writes one constant-colour pixel per cycle with no memory traffic.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_addr/mem_read/mem_ready     read request channel
//   mem_data/mem_valid              in-order read responses
//   ctrl_*                          command parameters, latched on a ctrl_start rising edge
//   ctrl_busy                       command in progress
//   fb_x/fb_y/fb_color/fb_write     framebuffer write port; only on-screen pixels are written
module gpu_blitter #(
  parameter int FB_WIDTH        = 400,
  parameter int FB_HEIGHT       = 240,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(FB_WIDTH) + 3,
  localparam int CH = $clog2(FB_HEIGHT) + 3,
  localparam int XW = $clog2(FB_WIDTH) + 1,
  localparam int YW = $clog2(FB_HEIGHT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [31:0]   mem_addr,
  output logic          mem_read,
  input  logic          mem_ready,
  input  logic [15:0]   mem_data,
  input  logic          mem_valid,
  input  logic [31:0]   ctrl_address,
  input  logic [15:0]   ctrl_address_x,
  input  logic [15:0]   ctrl_address_y,
  input  logic [15:0]   ctrl_image_width,
  input  logic [CW-1:0] ctrl_width,
  input  logic [CH-1:0] ctrl_height,
  input  logic [CW-1:0] ctrl_x,
  input  logic [CH-1:0] ctrl_y,
  input  logic [1:0]    ctrl_mode,
  input  logic          ctrl_flip_x,
  input  logic          ctrl_flip_y,
  input  logic [15:0]   ctrl_color,
  input  logic          ctrl_start,
  output logic          ctrl_busy,
  output logic [XW-1:0] fb_x,
  output logic [YW-1:0] fb_y,
  output logic [15:0]   fb_color,
  output logic          fb_write
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] ONE_W = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CH-1:0] ONE_H = {{(CH-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0] ONE_O = {{(OW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FILL = 2'd3} state_t;

  state_t        state_r, state_s;
  logic          start_d_r;
  logic [31:0]   base_r;
  logic [15:0]   ax_r, ay_r, iw_r, color_r;
  logic [CW-1:0] w_r, x_r, col_r;
  logic [CH-1:0] h_r, y_r, row_r;
  logic [1:0]    mode_r;
  logic          flip_x_r, flip_y_r;
  logic [OW-1:0] out_r, out_next_s;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] tag_x_r [MAX_OUTSTANDING];
  logic [CH-1:0] tag_y_r [MAX_OUTSTANDING];

  logic          start_s, zero_s, last_s, accept_s, resp_s, fill_s;
  logic [CW-1:0] sc_s, dest_x_s, px_s;
  logic [CH-1:0] sr_s, dest_y_s, py_s;
  logic [31:0]   lin_s, addr_s;
  logic [15:0]   pc_s;
  logic          act_s, in_range_s, opaque_s;

  // Circular pointer advance for a FIFO whose depth need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  assign start_s  = ctrl_start & ~start_d_r;
  assign zero_s   = (w_r == {CW{1'b0}}) || (h_r == {CH{1'b0}});
  assign last_s   = (col_r == w_r - ONE_W) && (row_r == h_r - ONE_H);
  assign mem_read = (state_r == ISSUE) && !zero_s && (out_r < OW'(MAX_OUTSTANDING));
  assign accept_s = mem_read && mem_ready;
  // A response with nothing outstanding (e.g. one left over from before a reset) is ignored
  assign resp_s   = mem_valid && (out_r != {OW{1'b0}}) && ((state_r == ISSUE) || (state_r == DRAIN));
  assign fill_s   = (state_r == FILL) && !zero_s;

  assign sc_s     = flip_x_r ? (w_r - ONE_W - col_r) : col_r;
  assign sr_s     = flip_y_r ? (h_r - ONE_H - row_r) : row_r;
  assign lin_s    = (32'(ay_r) + 32'(sr_s)) * {16'd0, iw_r} + {16'd0, ax_r} + 32'(sc_s);
  assign addr_s   = base_r + {lin_s[30:0], 1'b0};
  // Counters only move on acceptance, so the address holds through a stall
  assign mem_addr = (state_r == ISSUE) ? addr_s : 32'd0;

  assign dest_x_s = x_r + col_r;
  assign dest_y_s = y_r + row_r;
  assign ctrl_busy = (state_r != IDLE);

  // Outstanding-count update: simultaneous accept and response cancel out
  always_comb begin
    out_next_s = out_r;
    if (accept_s && !resp_s) begin
      out_next_s = out_r + ONE_O;
    end else if (!accept_s && resp_s) begin
      out_next_s = out_r - ONE_O;
    end else begin
      out_next_s = out_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          if (ctrl_mode == 2'b01) state_s = FILL;
          else                    state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (zero_s)                   state_s = IDLE;
        else if (accept_s && last_s)  state_s = DRAIN;
        else                          state_s = ISSUE;
      end
      DRAIN: begin
        if (out_next_s == {OW{1'b0}}) state_s = IDLE;
        else                          state_s = DRAIN;
      end
      FILL: begin
        if (zero_s || last_s) state_s = IDLE;
        else                  state_s = FILL;
      end
      default: state_s = IDLE;
    endcase
  end

  // Pixel source select: memory response in blit modes, constant colour in fill
  always_comb begin
    px_s  = {CW{1'b0}};
    py_s  = {CH{1'b0}};
    pc_s  = 16'd0;
    act_s = 1'b0;
    if (resp_s) begin
      px_s  = tag_x_r[rd_ptr_r];
      py_s  = tag_y_r[rd_ptr_r];
      pc_s  = mem_data;
      act_s = 1'b1;
    end else if (fill_s) begin
      px_s  = dest_x_s;
      py_s  = dest_y_s;
      pc_s  = color_r;
      act_s = 1'b1;
    end else begin
      act_s = 1'b0;
    end
  end

  // Mode 11 behaves as transparent blit; only fill and opaque blit ignore colour bit 0
  assign opaque_s   = (mode_r == 2'b01) || (mode_r == 2'b10);
  assign in_range_s = !px_s[CW-1] && (px_s < CW'(FB_WIDTH)) &&
                      !py_s[CH-1] && (py_s < CH'(FB_HEIGHT));
  assign fb_write   = act_s && in_range_s && (opaque_s || pc_s[0]);
  assign fb_x       = px_s[XW-1:0];
  assign fb_y       = py_s[YW-1:0];
  assign fb_color   = pc_s;

  // Command parameter latch, captured on the accepted start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_r   <= 32'd0;
      ax_r     <= 16'd0;
      ay_r     <= 16'd0;
      iw_r     <= 16'd0;
      color_r  <= 16'd0;
      w_r      <= {CW{1'b0}};
      h_r      <= {CH{1'b0}};
      x_r      <= {CW{1'b0}};
      y_r      <= {CH{1'b0}};
      mode_r   <= 2'b00;
      flip_x_r <= 1'b0;
      flip_y_r <= 1'b0;
    end else if ((state_r == IDLE) && start_s) begin
      base_r   <= ctrl_address;
      ax_r     <= ctrl_address_x;
      ay_r     <= ctrl_address_y;
      iw_r     <= ctrl_image_width;
      color_r  <= ctrl_color;
      w_r      <= ctrl_width;
      h_r      <= ctrl_height;
      x_r      <= ctrl_x;
      y_r      <= ctrl_y;
      mode_r   <= ctrl_mode;
      flip_x_r <= ctrl_flip_x;
      flip_y_r <= ctrl_flip_y;
    end
  end

  // State, start-edge detector, outstanding count and traversal counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      start_d_r <= 1'b0;
      out_r     <= {OW{1'b0}};
      col_r     <= {CW{1'b0}};
      row_r     <= {CH{1'b0}};
    end else begin
      state_r   <= state_s;
      start_d_r <= ctrl_start;
      out_r     <= out_next_s;
      if ((state_r == IDLE) && start_s) begin
        col_r <= {CW{1'b0}};
        row_r <= {CH{1'b0}};
      end else if (accept_s || fill_s) begin
        if (col_r == w_r - ONE_W) begin
          col_r <= {CW{1'b0}};
          row_r <= row_r + ONE_H;
        end else begin
          col_r <= col_r + ONE_W;
        end
      end
    end
  end

  // Destination tag FIFO: one entry per read in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_x_r[i] <= {CW{1'b0}};
        tag_y_r[i] <= {CH{1'b0}};
      end
    end else begin
      if (accept_s) begin
        tag_x_r[wr_ptr_r] <= dest_x_s;
        tag_y_r[wr_ptr_r] <= dest_y_s;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (resp_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

endmodule

// File: tb/tb_gpu_blitter.sv
// Testbench for gpu_blitter: directed commands, a memory model with
// configurable latency and ready toggling, and scoreboards for read
// addresses and framebuffer writes that are checked by separate monitors.
module tb_gpu_blitter;
  localparam int CW = 12;
  localparam int CH = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   mem_addr;
  logic          mem_read;
  logic          mem_ready = 1'b1;
  logic [15:0]   mem_data = 16'd0;
  logic          mem_valid = 1'b0;
  logic [31:0]   ctrl_address = 32'd0;
  logic [15:0]   ctrl_address_x = 16'd0, ctrl_address_y = 16'd0, ctrl_image_width = 16'd0;
  logic [CW-1:0] ctrl_width = '0, ctrl_x = '0;
  logic [CH-1:0] ctrl_height = '0, ctrl_y = '0;
  logic [1:0]    ctrl_mode = 2'b00;
  logic          ctrl_flip_x = 1'b0, ctrl_flip_y = 1'b0;
  logic [15:0]   ctrl_color = 16'd0;
  logic          ctrl_start = 1'b0;
  logic          ctrl_busy;
  logic [9:0]    fb_x;
  logic [8:0]    fb_y;
  logic [15:0]   fb_color;
  logic          fb_write;

  gpu_blitter dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_ready(mem_ready),
    .mem_data(mem_data), .mem_valid(mem_valid),
    .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
    .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
    .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
    .ctrl_x(ctrl_x), .ctrl_y(ctrl_y), .ctrl_mode(ctrl_mode),
    .ctrl_flip_x(ctrl_flip_x), .ctrl_flip_y(ctrl_flip_y),
    .ctrl_color(ctrl_color), .ctrl_start(ctrl_start), .ctrl_busy(ctrl_busy),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} resp_t;
  typedef struct packed {logic [9:0] x; logic [8:0] y; logic [15:0] c;} pix_t;

  resp_t       resp_q[$];
  pix_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] t1_addr [8];

  int compared = 0, failed = 0, cyc = 0;
  int lat = 1, accepts_seen = 0, writes_seen = 0, peak = 0;
  bit ready_toggle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: one hand-picked transparent pixel, otherwise address with bit0 set
  function automatic logic [15:0] pix(input logic [31:0] a);
    if (a == 32'h0000_2000) return 16'h0002;
    else                    return a[15:0] | 16'h0001;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [9:0] x, input logic [8:0] y, input logic [15:0] c);
    pix_t e;
    e.x = x; e.y = y; e.c = c;
    exp_q.push_back(e);
  endtask

  // Expected reads/writes for the 4x2 reference blit at (10,5)
  task automatic push_blit(input bit flip);
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = flip ? t1_addr[7-i] : t1_addr[i];
      exp_addr_q.push_back(a);
      push_wr(10'(10 + i % 4), 9'(5 + i / 4), pix(a));
    end
  endtask

  // Memory request monitor: address scoreboard, stall stability, in-flight peak
  initial begin
    bit stall_prev;
    logic [31:0] stall_addr;
    int inflight;
    stall_prev = 1'b0;
    stall_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (stall_prev && mem_read) chk("addr_stable", mem_addr, stall_addr);
      stall_prev = mem_read && !mem_ready;
      stall_addr = mem_addr;
      if (mem_read && mem_ready) begin
        inflight = resp_q.size() + (mem_valid ? 1 : 0) + 1;
        if (inflight > peak) peak = inflight;
        accepts_seen++;
        if (exp_addr_q.size() == 0) begin
          compared++; failed++;
          $display("FAIL unexpected_read: got addr %0h expected no read", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
        resp_q.push_back('{mem_addr, cyc + lat});
      end
    end
  end

  // Memory response driver: in-order, each response no earlier than its due cycle
  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      mem_data  = 16'd0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        r = resp_q.pop_front();
        mem_valid = 1'b1;
        mem_data  = pix(r.addr);
      end
      mem_ready = ready_toggle ? cyc[0] : 1'b1;
    end
  end

  // Framebuffer monitor: every write must match the next expected pixel
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (fb_write === 1'b1) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          compared++; failed++;
          $display("FAIL unexpected_write: got (%0d,%0d,%0h) expected none", fb_x, fb_y, fb_color);
        end else begin
          e = exp_q.pop_front();
          chk("fb_pixel{x,y,c}", {fb_x, fb_y, fb_color}, {e.x, e.y, e.c});
        end
      end
    end
  end

  task automatic issue_start(input logic [31:0] base, input logic [15:0] ax, input logic [15:0] ay,
                             input logic [15:0] iw, input logic [CW-1:0] w, input logic [CH-1:0] h,
                             input logic [CW-1:0] x, input logic [CH-1:0] y, input logic [1:0] mode,
                             input logic fx, input logic fy, input logic [15:0] color);
    @(posedge clk);
    #1;
    ctrl_address = base; ctrl_address_x = ax; ctrl_address_y = ay; ctrl_image_width = iw;
    ctrl_width = w; ctrl_height = h; ctrl_x = x; ctrl_y = y; ctrl_mode = mode;
    ctrl_flip_x = fx; ctrl_flip_y = fy; ctrl_color = color; ctrl_start = 1'b1;
    @(posedge clk);
    #1;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (ctrl_busy) busy_cnt++;
      else break;
    end
    if (ctrl_busy) begin
      compared++; failed++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0 within 3000 cycles");
    end
    for (int g = 0; g < 200 && resp_q.size() > 0; g++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic end_test(input string name);
    chk({name, "_pending_writes"}, exp_q.size(), 0);
    chk({name, "_pending_reads"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    int busy_cnt, a0, w0;
    t1_addr = '{32'h1024, 32'h1026, 32'h1028, 32'h102A, 32'h1044, 32'h1046, 32'h1048, 32'h104A};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_fb_write", fb_write, 0);
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fb_x", fb_x, 0);
    chk("rst_fb_y", fb_y, 0);
    chk("rst_fb_color", fb_color, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1: 4x2 blit, one-cycle memory
    lat = 1;
    push_blit(1'b0);
    issue_start(32'h1000, 16'd2, 16'd1, 16'd16, 12'd4, 11'd2, 12'd10, 11'd5, 2'b00, 1'b0, 1'b0, 16'd0);
    wait_done(busy_cnt);
    end_test("blit");

    // 2: same blit mirrored both ways
    push_blit(1'b1);
    issue_start(32'h1000, 16'd2, 16'd1, 16'd16, 12'd4, 11'd2, 12'd10, 11'd5, 2'b00, 1'b1, 1'b1, 16'd0);
    wait_done(busy_cnt);
    end_test("flip");

    // 3: latency 6, toggling ready
    lat = 6; ready_toggle = 1'b1; peak = 0;
    push_blit(1'b0);
    issue_start(32'h1000, 16'd2, 16'd1, 16'd16, 12'd4, 11'd2, 12'd10, 11'd5, 2'b00, 1'b0, 1'b0, 16'd0);
    wait_done(busy_cnt);
    end_test("latency");
    chk("peak_outstanding_le_4", (peak <= 4), 1);
    lat = 1; ready_toggle = 1'b0;

    // 4: fill 3x3 at (-1,238), clipped to 2x2
    a0 = accepts_seen; w0 = writes_seen;
    push_wr(10'd0, 9'd238, 16'h1234);
    push_wr(10'd1, 9'd238, 16'h1234);
    push_wr(10'd0, 9'd239, 16'h1234);
    push_wr(10'd1, 9'd239, 16'h1234);
    issue_start(32'h0, 16'd0, 16'd0, 16'd0, 12'd3, 11'd3, 12'hFFF, 11'd238, 2'b01, 1'b0, 1'b0, 16'h1234);
    wait_done(busy_cnt);
    chk("fill_busy_cycles", busy_cnt, 9);
    chk("fill_reads", accepts_seen - a0, 0);
    chk("fill_writes", writes_seen - w0, 4);
    end_test("fill");

    // 5: transparent pixel 0x0002 skipped in mode 00, written in mode 10
    exp_addr_q.push_back(32'h1FFE);
    exp_addr_q.push_back(32'h2000);
    push_wr(10'd20, 9'd30, 16'h1FFF);
    issue_start(32'h1FFE, 16'd0, 16'd0, 16'd16, 12'd2, 11'd1, 12'd20, 11'd30, 2'b00, 1'b0, 1'b0, 16'd0);
    wait_done(busy_cnt);
    end_test("transparent");
    exp_addr_q.push_back(32'h1FFE);
    exp_addr_q.push_back(32'h2000);
    push_wr(10'd20, 9'd30, 16'h1FFF);
    push_wr(10'd21, 9'd30, 16'h0002);
    issue_start(32'h1FFE, 16'd0, 16'd0, 16'd16, 12'd2, 11'd1, 12'd20, 11'd30, 2'b10, 1'b0, 1'b0, 16'd0);
    wait_done(busy_cnt);
    end_test("opaque");

    // 6: zero width
    a0 = accepts_seen; w0 = writes_seen;
    issue_start(32'h1000, 16'd0, 16'd0, 16'd16, 12'd0, 11'd2, 12'd0, 11'd0, 2'b00, 1'b0, 1'b0, 16'd0);
    wait_done(busy_cnt);
    chk("zero_busy_cycles", busy_cnt, 1);
    chk("zero_reads", accepts_seen - a0, 0);
    chk("zero_writes", writes_seen - w0, 0);

    // 7: reset while draining three outstanding reads
    lat = 10;
    a0 = accepts_seen;
    exp_addr_q.push_back(32'h1000);
    exp_addr_q.push_back(32'h1002);
    exp_addr_q.push_back(32'h1004);
    issue_start(32'h1000, 16'd0, 16'd0, 16'd16, 12'd3, 11'd1, 12'd50, 11'd60, 2'b00, 1'b0, 1'b0, 16'd0);
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (accepts_seen - a0 >= 3) break;
    end
    @(posedge clk);
    #2;
    chk("drain_busy_before_reset", ctrl_busy, 1);
    chk("drain_responses_pending", resp_q.size(), 3);
    reset = 1'b0;
    #1;
    chk("reset_busy_drop", ctrl_busy, 0);
    chk("reset_write_drop", fb_write, 0);
    chk("reset_read_drop", mem_read, 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    w0 = writes_seen;
    for (int g = 0; g < 200 && resp_q.size() > 0; g++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("late_response_writes", writes_seen - w0, 0);
    chk("idle_after_reset", ctrl_busy, 0);
    end_test("reset");

    // Next command after the reset runs normally
    lat = 1;
    push_blit(1'b0);
    issue_start(32'h1000, 16'd2, 16'd1, 16'd16, 12'd4, 11'd2, 12'd10, 11'd5, 2'b00, 1'b0, 1'b0, 16'd0);
    wait_done(busy_cnt);
    end_test("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
